// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter and burst sequencer for the shared 16-bit 8:1 bus mux.
// Grants one source at a time, runs a valid/ready beat handshake and bounds each grant to HOLD_MAX beats.
module rr_bus_arbiter8 #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [7:0]       last,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic [7:0]       gnt,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_sel;
  logic [2:0]       w_sel_nxt;
  logic [7:0]       r_gnt;
  logic [7:0]       w_gnt_nxt;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic [2:0]       w_winner;
  logic             w_valid;
  logic             w_beat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_release;

  // Rotating priority scan: walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    logic [2:0] idx;
    w_winner = r_ptr;
    idx      = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = r_ptr + 3'(i);
      if (req[idx]) begin
        w_winner = idx;
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // Beat handshake and release qualification for the granted source.
  always_comb begin
    if (r_state == ST_GRANT) begin
      w_valid = req[r_sel];
    end else begin
      w_valid = 1'b0;
    end
    w_beat    = w_valid & out_ready;
    w_cnt_inc = r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    w_release = ~req[r_sel]
              | (w_beat & last[r_sel])
              | (w_beat & (w_cnt_inc == CNT_W'(HOLD_MAX)));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_gnt_nxt      = r_gnt;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_busy_nxt     = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt    = ST_GRANT;
          w_sel_nxt      = w_winner;
          w_gnt_nxt      = 8'd1 << w_winner;
          w_beat_cnt_nxt = {CNT_W{1'b0}};
          w_busy_nxt     = 1'b1;
        end else begin
          w_gnt_nxt      = 8'd0;
          w_busy_nxt     = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = 8'd0;
          w_busy_nxt     = 1'b0;
          w_beat_cnt_nxt = {CNT_W{1'b0}};
          w_ptr_nxt      = r_sel + 3'd1;
        end else if (w_beat) begin
          w_beat_cnt_nxt = w_cnt_inc;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_gnt_nxt      = 8'd0;
        w_busy_nxt     = 1'b0;
        w_beat_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= 3'd0;
      r_gnt      <= 8'd0;
      r_ptr      <= 3'd0;
      r_beat_cnt <= {CNT_W{1'b0}};
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign beat_cnt  = r_beat_cnt;
  assign out_valid = w_valid;

endmodule
